// File: rtl/ram64_arbiter.sv
// Two-port round-robin arbiter and zero-fill sequencer in front of a 64x16 ram64.
// Define RAM64_ARB_FIXED_PRIO_EN to give port 0 fixed priority over port 1.
module ram64_arbiter #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_data,
    output logic          ram_load,
    input  logic [DW-1:0] ram_out
);

    // Handshake: a requester holds req/we/adr/wdata until it sees gnt high in
    // the same cycle; a granted read returns rdata with rvalid one cycle later.

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] cnt_q;
    logic          pick1;

`ifdef RAM64_ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    // last_q names the port served most recently; the other one wins a tie.
    logic last_q;

    assign pick1 = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (gnt0) begin
            last_q <= 1'b0;
        end else if (gnt1) begin
            last_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ram_adr  = adr0;
        ram_data = wdata0;
        ram_load = 1'b0;
        case (state_q)
            ARB: begin
                if (pick1) begin
                    gnt1     = 1'b1;
                    ram_adr  = adr1;
                    ram_data = wdata1;
                    ram_load = we1;
                end else if (req0) begin
                    gnt0     = 1'b1;
                    ram_load = we0;
                end
                if (clr) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                ram_adr  = cnt_q;
                ram_data = '0;
                ram_load = 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        // A grant issued while reset is high must not reach the RAM.
        if (reset) begin
            gnt0     = 1'b0;
            gnt1     = 1'b0;
            ram_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            cnt_q   <= '0;
            busy    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == CLEAR);
            cnt_q   <= (state_q == ARB) ? '0 : cnt_q + 1'b1;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) begin
                rdata0 <= ram_out;
            end
            if (gnt1 && !we1) begin
                rdata1 <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: behavioural ram64 plus a cycle-level reference model
// of the arbitration, read latency and zero-fill rules.
module tb_ram64_arbiter;
    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
`ifdef RAM64_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, clr;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_load;
    logic [DW-1:0] rdata0, rdata1, ram_data, ram_out;
    logic [AW-1:0] ram_adr;

    always #5 clk = ~clk;

    ram64_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .adr1(adr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .clr(clr), .busy(busy),
        .ram_adr(ram_adr), .ram_data(ram_data), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    // ram64 stand-in: combinational read, write on the rising edge.
    logic [DW-1:0] ram [DEPTH];
    assign ram_out = ram[ram_adr];
    always @(posedge clk) if (ram_load) ram[ram_adr] <= ram_data;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last = 1;
    bit            m_clear = 0;
    int            m_cnt = 0;
    logic          m_rv0 = 0, m_rv1 = 0;
    logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;

    logic [1:0]    g_obs;
    logic          load_obs;
    bit            any_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at
    // the edge, then check registered outputs just after it.
    task automatic cycle();
        int   w;
        logic exp_load;
        @(negedge clk);
        w = -1;
        if (!reset && !m_clear) begin
            if (req0 && req1) w = FIXED ? 0 : 1 - m_last;
            else if (req0)    w = 0;
            else if (req1)    w = 1;
        end
        exp_load = reset ? 1'b0 : m_clear ? 1'b1 :
                   (w == 0) ? we0 : (w == 1) ? we1 : 1'b0;
        g_obs    = {gnt1, gnt0};
        load_obs = ram_load;
        if (gnt0 || gnt1) any_gnt = 1;
        chk("gnt0", {31'd0, gnt0}, {31'd0, w == 0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, w == 1});
        chk("ram_load", {31'd0, ram_load}, {31'd0, exp_load});
        if (m_clear && !reset) begin
            chk("clr_adr", {26'd0, ram_adr}, m_cnt);
            chk("clr_data", {16'd0, ram_data}, 0);
        end else if (w == 0) begin
            chk("adr_p0", {26'd0, ram_adr}, {26'd0, adr0});
            chk("data_p0", {16'd0, ram_data}, {16'd0, wdata0});
        end else if (w == 1) begin
            chk("adr_p1", {26'd0, ram_adr}, {26'd0, adr1});
            chk("data_p1", {16'd0, ram_data}, {16'd0, wdata1});
        end
        @(posedge clk);
        if (reset) begin
            m_clear = 0; m_cnt = 0; m_last = 1;
            m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
        end else if (m_clear) begin
            m_mem[m_cnt] = '0;
            m_rv0 = 0; m_rv1 = 0;
            if (m_cnt == DEPTH - 1) m_clear = 0;
            m_cnt++;
        end else begin
            m_rv0 = (w == 0) && !we0;
            m_rv1 = (w == 1) && !we1;
            if (m_rv0) m_rd0 = m_mem[adr0];
            if (m_rv1) m_rd1 = m_mem[adr1];
            if (w == 0 && we0) m_mem[adr0] = wdata0;
            if (w == 1 && we1) m_mem[adr1] = wdata1;
            if (w >= 0) m_last = w;
            if (clr) begin m_clear = 1; m_cnt = 0; end
        end
        #1;
        chk("rvalid0", {31'd0, rvalid0}, {31'd0, m_rv0});
        chk("rvalid1", {31'd0, rvalid1}, {31'd0, m_rv1});
        chk("rdata0", {16'd0, rdata0}, {16'd0, m_rd0});
        chk("rdata1", {16'd0, rdata1}, {16'd0, m_rd1});
        chk("busy", {31'd0, busy}, {31'd0, m_clear});
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = 1; we0 = 1; adr0 = a; wdata0 = d;
        cycle();
        req0 = 0; we0 = 0;
    endtask

    task automatic rd0(input logic [AW-1:0] a, output logic [DW-1:0] d);
        req0 = 1; we0 = 0; adr0 = a;
        cycle();
        req0 = 0;
        d = rdata0;
    endtask

    initial begin
        logic [DW-1:0] d;
        int            n;
        reset = 1; clr = 0;
        req0 = 0; we0 = 0; adr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; adr1 = '0; wdata1 = '0;

        // Reset state.
        cycle();
        cycle();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rdata0", {16'd0, rdata0}, 0);
        reset = 0;

        // Write then read back on port 0.
        wr0(6'd5, 16'h1234);
        chk("wb_gnt_w", {30'd0, g_obs}, 2'b01);
        rd0(6'd5, d);
        chk("wb_gnt_r", {30'd0, g_obs}, 2'b01);
        chk("wb_rvalid0", {31'd0, rvalid0}, 1);
        chk("wb_rdata0", {16'd0, d}, 16'h1234);

        // Contention right after reset.
        reset = 1; cycle(); reset = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; adr0 = 6'd5; adr1 = 6'd5;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("contend", {30'd0, g_obs}, (FIXED || k % 2 == 0) ? 2'b01 : 2'b10);
        end
        req0 = 0; req1 = 0;
        cycle();

        // Fill with FFFF, clear, and raise a port 1 read at clear cycle 10.
        for (int i = 0; i < DEPTH; i++) wr0(i[AW-1:0], 16'hFFFF);
        clr = 1; cycle(); clr = 0;
        any_gnt = 0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 10) begin req1 = 1; we1 = 0; adr1 = 6'd7; end
            cycle();
            n++;
        end
        chk("clr_len", n, DEPTH);
        chk("clr_no_gnt", {31'd0, any_gnt}, 0);
        cycle();
        chk("post_clr_gnt1", {30'd0, g_obs}, 2'b10);
        chk("post_clr_rvalid1", {31'd0, rvalid1}, 1);
        chk("post_clr_rdata1", {16'd0, rdata1}, 0);
        req1 = 0;
        rd0(6'd0, d);  chk("clr_rd0", {16'd0, d}, 0);
        rd0(6'd31, d); chk("clr_rd31", {16'd0, d}, 0);
        rd0(6'd63, d); chk("clr_rd63", {16'd0, d}, 0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            adr0 = AW'($urandom_range(0, DEPTH - 1)); wdata0 = DW'($urandom);
            adr1 = AW'($urandom_range(0, DEPTH - 1)); wdata1 = DW'($urandom);
            clr = ($urandom_range(0, 59) == 0);
            cycle();
            clr = 0;
        end
        req0 = 0; req1 = 0;
        n = 0;
        while (busy && n < 100) begin cycle(); n++; end
        chk("rand_drain", {31'd0, busy}, 0);

        // Reset in the middle of a clear.
        for (int i = 0; i < DEPTH; i++) wr0(i[AW-1:0], 16'hAAAA);
        clr = 1; cycle(); clr = 0;
        for (int i = 0; i < 20; i++) cycle();
        reset = 1; cycle(); reset = 0;
        chk("midclr_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 20; i++) begin
            rd0(i[AW-1:0], d);
            chk("midclr_low", {16'd0, d}, 0);
        end
        rd0(6'd40, d);
        chk("midclr_adr40", {16'd0, d}, 16'hAAAA);

        // Write during reset is suppressed.
        reset = 1; req0 = 1; we0 = 1; adr0 = 6'd3; wdata0 = 16'h5555;
        cycle();
        chk("rstwr_load", {31'd0, load_obs}, 0);
        chk("rstwr_rvalid0", {31'd0, rvalid0}, 0);
        reset = 0; req0 = 0; we0 = 0;
        rd0(6'd3, d);
        chk("rstwr_adr3", {16'd0, d}, 0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
